// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Connects the parallel side of an SPI slave and a local host port to one
//   single-port RAM. It decodes SPI command words, holds the SPI write and read
//   address registers, and issues one RAM access at a time. When both sides
//   want the RAM in the same cycle, the side that lost the previous tie wins.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   spi_rx_data[9:0]  SPI command word: [9:8] opcode, [7:0] payload
//   spi_rx_valid      level; a command is taken only on its rising edge
//   spi_tx_data[7:0]  SPI read data
//   spi_tx_valid      spi_tx_data valid, held until the next accepted command
//   spi_ovf           sticky flag: an SPI data command was dropped
//   host_req/we/addr/wdata  host request, held until host_gnt
//   host_gnt          one-cycle pulse: host request taken
//   host_rvalid       one-cycle pulse: host_rdata valid
//   host_rdata[7:0]   host read data
//   mem_en/we/addr/wdata  RAM strobe (one cycle per access) and controls
//   mem_rdata[7:0]    RAM read data, valid the cycle after a read strobe
//
// Handshakes
//   host:  host_req plus host_we/host_addr/host_wdata are held stable until the
//          host sees host_gnt; host_req still high in the cycle after host_gnt
//          is a new request. Read data returns as a single host_rvalid pulse.
//   spi:   spi_rx_valid is a level; only its rising edge is a command. There is
//          no back-pressure, so a data command that finds the pending slot full
//          is dropped and recorded in spi_ovf.
//
// Opcodes: 00 set write address, 01 write data, 10 set read address, 11 read.

module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [7:0]           spi_tx_data,
  output logic                 spi_tx_valid,
  output logic                 spi_ovf,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // SPI command decode
  logic       rx_prev_q;
  logic       accept;
  logic [1:0] op;
  logic [7:0] payload;

  assign accept  = spi_rx_valid & ~rx_prev_q;
  assign op      = spi_rx_data[9:8];
  assign payload = spi_rx_data[7:0];

  // Address registers and the single SPI pending slot
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 slot_full_q, slot_full_d;
  logic                 slot_we_q, slot_we_d;
  logic [ADDR_SIZE-1:0] slot_addr_q, slot_addr_d;
  logic [7:0]           slot_data_q, slot_data_d;
  logic                 spi_ovf_d;

  // Tie-break flag: 1 means SPI wins the next tie.
  logic spi_wins_tie_q, spi_wins_tie_d;

  // Owner and direction of the access in flight
  logic cur_host_q, cur_host_d;
  logic cur_read_q, cur_read_d;

  // Next values of the registered outputs
  logic                 mem_en_d, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_d;
  logic [7:0]           mem_wdata_d;
  logic                 host_gnt_d, host_rvalid_d;
  logic [7:0]           host_rdata_d;
  logic [7:0]           spi_tx_data_d;
  logic                 spi_tx_valid_d;

  logic grant_spi, grant_host;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_ARB;
      rx_prev_q      <= 1'b0;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      slot_full_q    <= 1'b0;
      slot_we_q      <= 1'b0;
      slot_addr_q    <= '0;
      slot_data_q    <= '0;
      spi_ovf        <= 1'b0;
      spi_wins_tie_q <= 1'b1;
      cur_host_q     <= 1'b0;
      cur_read_q     <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      host_gnt       <= 1'b0;
      host_rvalid    <= 1'b0;
      host_rdata     <= '0;
      spi_tx_data    <= '0;
      spi_tx_valid   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_prev_q      <= spi_rx_valid;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      slot_full_q    <= slot_full_d;
      slot_we_q      <= slot_we_d;
      slot_addr_q    <= slot_addr_d;
      slot_data_q    <= slot_data_d;
      spi_ovf        <= spi_ovf_d;
      spi_wins_tie_q <= spi_wins_tie_d;
      cur_host_q     <= cur_host_d;
      cur_read_q     <= cur_read_d;
      mem_en         <= mem_en_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      host_gnt       <= host_gnt_d;
      host_rvalid    <= host_rvalid_d;
      host_rdata     <= host_rdata_d;
      spi_tx_data    <= spi_tx_data_d;
      spi_tx_valid   <= spi_tx_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    slot_full_d    = slot_full_q;
    slot_we_d      = slot_we_q;
    slot_addr_d    = slot_addr_q;
    slot_data_d    = slot_data_q;
    spi_ovf_d      = spi_ovf;
    spi_wins_tie_d = spi_wins_tie_q;
    cur_host_d     = cur_host_q;
    cur_read_d     = cur_read_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    host_gnt_d     = 1'b0;
    host_rvalid_d  = 1'b0;
    host_rdata_d   = host_rdata;
    spi_tx_data_d  = spi_tx_data;
    // Any accepted command retires the previous read result; an RDATA
    // capture below overrides this in the same cycle.
    spi_tx_valid_d = spi_tx_valid & ~accept;
    grant_spi      = 1'b0;
    grant_host     = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (slot_full_q && host_req) begin
          grant_spi      = spi_wins_tie_q;
          grant_host     = ~spi_wins_tie_q;
          spi_wins_tie_d = ~spi_wins_tie_q;
        end else begin
          grant_spi  = slot_full_q;
          grant_host = host_req;
        end

        if (grant_spi) begin
          mem_en_d    = 1'b1;
          mem_we_d    = slot_we_q;
          mem_addr_d  = slot_addr_q;
          mem_wdata_d = slot_data_q;
          slot_full_d = 1'b0;
          cur_host_d  = 1'b0;
          cur_read_d  = ~slot_we_q;
          state_d     = ST_ACCESS;
        end else if (grant_host) begin
          mem_en_d    = 1'b1;
          mem_we_d    = host_we;
          mem_addr_d  = host_addr;
          mem_wdata_d = host_wdata;
          host_gnt_d  = 1'b1;
          cur_host_d  = 1'b1;
          cur_read_d  = ~host_we;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        state_d = cur_read_q ? ST_RDATA : ST_ARB;
      end

      ST_RDATA: begin
        if (cur_host_q) begin
          host_rdata_d  = mem_rdata;
          host_rvalid_d = 1'b1;
        end else begin
          spi_tx_data_d  = mem_rdata;
          spi_tx_valid_d = 1'b1;
        end
        state_d = ST_ARB;
      end

      default: state_d = ST_ARB;
    endcase

    // Command decode runs after arbitration so a slot being issued this cycle
    // can take a new entry without counting as an overrun.
    if (accept) begin
      case (op)
        2'b00: wr_addr_d = ADDR_SIZE'(payload);
        2'b10: rd_addr_d = ADDR_SIZE'(payload);
        default: begin
          if (slot_full_q && !grant_spi) begin
            spi_ovf_d = 1'b1;
          end else begin
            slot_full_d = 1'b1;
            slot_we_d   = ~op[1];
            slot_addr_d = op[1] ? rd_addr_q : wr_addr_q;
            slot_data_d = payload;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter
//   Directed bench for spi_ram_arbiter with a behavioural RAM, a write monitor
//   feeding an observed-write log, and hand-computed expectations.

module tb_spi_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       spi_ovf;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .spi_ovf      (spi_ovf),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // ---------------- RAM model ----------------
  logic [7:0] ram [256];
  logic       pre_en;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- write monitor / scoreboard ----------------
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (mem_en && mem_we) obs_q.push_back({mem_addr, mem_wdata});
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  // Returns one edge after acceptance, with spi_rx_valid low on that edge.
  task automatic spi_send(input logic [1:0] op, input logic [7:0] pl);
    spi_rx_data  = {op, pl};
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int waited;
    logic got;

    rst_n        = 1'b0;
    spi_rx_data  = '0;
    spi_rx_valid = 1'b0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    pre_en       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    idle(3);

    // Reset state
    check("rst_mem_en",   32'(mem_en), 0);
    check("rst_mem_we",   32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_gnt",      32'(host_gnt), 0);
    check("rst_rvalid",   32'(host_rvalid), 0);
    check("rst_rdata",    32'(host_rdata), 0);
    check("rst_tx_valid", 32'(spi_tx_valid), 0);
    check("rst_tx_data",  32'(spi_tx_data), 0);
    check("rst_ovf",      32'(spi_ovf), 0);
    rst_n = 1'b1;
    tick();

    // 1: SPI write 0xAB at 0x12
    spi_send(2'b00, 8'h12);
    check("t1_no_access", 32'(mem_en), 0);
    spi_send(2'b01, 8'hAB);
    check("t1_mem_en",    32'(mem_en), 1);
    check("t1_mem_we",    32'(mem_we), 1);
    check("t1_mem_addr",  32'(mem_addr), 32'h12);
    check("t1_mem_wdata", 32'(mem_wdata), 32'hAB);
    tick();
    check("t1_one_cycle", 32'(mem_en), 0);
    check("t1_ram",       32'(ram[8'h12]), 32'hAB);
    check("t1_ovf",       32'(spi_ovf), 0);

    // 2: SPI read at 0x34
    preload(8'h34, 8'h5C);
    spi_send(2'b10, 8'h34);
    spi_send(2'b11, 8'h00);
    check("t2_mem_en",   32'(mem_en), 1);
    check("t2_mem_we",   32'(mem_we), 0);
    check("t2_mem_addr", 32'(mem_addr), 32'h34);
    tick();
    check("t2_tx_early", 32'(spi_tx_valid), 0);
    tick();
    check("t2_tx_valid", 32'(spi_tx_valid), 1);
    check("t2_tx_data",  32'(spi_tx_data), 32'h5C);
    idle(2);
    check("t2_tx_held",  32'(spi_tx_valid), 1);
    spi_send(2'b00, 8'h00);
    check("t2_tx_clear", 32'(spi_tx_valid), 0);

    // 3: host read at 0x07
    preload(8'h07, 8'h99);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h07;
    tick();
    check("t3_gnt",      32'(host_gnt), 1);
    check("t3_mem_en",   32'(mem_en), 1);
    check("t3_mem_addr", 32'(mem_addr), 32'h07);
    tick();
    check("t3_gnt_pulse", 32'(host_gnt), 0);
    check("t3_rv_early",  32'(host_rvalid), 0);
    host_req = 1'b0;
    tick();
    check("t3_rvalid", 32'(host_rvalid), 1);
    check("t3_rdata",  32'(host_rdata), 32'h99);
    tick();
    check("t3_rv_pulse", 32'(host_rvalid), 0);

    // 4: repeated ties between SPI and host writes alternate
    spi_send(2'b00, 8'h40);
    base = obs_q.size();
    exp_q.push_back(16'h40A1);
    exp_q.push_back(16'h50B1);
    exp_q.push_back(16'h40A2);
    exp_q.push_back(16'h51B2);
    exp_q.push_back(16'h40A3);
    spi_rx_data  = {2'b01, 8'hA1};
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    host_req     = 1'b1;
    host_we      = 1'b1;
    host_addr    = 8'h50;
    host_wdata   = 8'hB1;
    tick();
    check("t4_tie1_spi",  32'(mem_addr), 32'h40);
    check("t4_tie1_gnt",  32'(host_gnt), 0);
    spi_rx_data  = {2'b01, 8'hA2};
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    tick();
    check("t4_tie2_host", 32'(host_gnt), 1);
    check("t4_tie2_addr", 32'(mem_addr), 32'h50);
    host_addr  = 8'h51;
    host_wdata = 8'hB2;
    idle(2);
    check("t4_tie3_spi",  32'(mem_wdata), 32'hA2);
    check("t4_tie3_gnt",  32'(host_gnt), 0);
    spi_rx_data  = {2'b01, 8'hA3};
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    tick();
    check("t4_tie4_host", 32'(host_gnt), 1);
    check("t4_tie4_addr", 32'(mem_addr), 32'h51);
    host_req = 1'b0;
    idle(2);
    check("t4_last_spi", 32'(mem_wdata), 32'hA3);
    tick();
    check("t4_nwr", 32'(obs_q.size() - base), 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < obs_q.size())
        check($sformatf("t4_wr%0d", i), 32'(obs_q[base + i]), 32'(exp_q[i]));
    end
    check("t4_ovf", 32'(spi_ovf), 0);

    // 5: overrun while host read holds the RAM
    idle(2);
    preload(8'h08, 8'h3C);
    host_req     = 1'b1;
    host_we      = 1'b0;
    host_addr    = 8'h08;
    spi_rx_data  = {2'b01, 8'hC1};
    spi_rx_valid = 1'b1;
    tick();
    check("t5_gnt",     32'(host_gnt), 1);
    check("t5_ovf_pre", 32'(spi_ovf), 0);
    spi_rx_valid = 1'b0;
    tick();
    spi_rx_data  = {2'b01, 8'hC2};
    spi_rx_valid = 1'b1;
    tick();
    check("t5_ovf",    32'(spi_ovf), 1);
    check("t5_rvalid", 32'(host_rvalid), 1);
    check("t5_rdata",  32'(host_rdata), 32'h3C);
    spi_rx_valid = 1'b0;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      tick();
      waited++;
      got = host_gnt;
    end
    check("t5_gnt_wait", 32'(got), 1);
    host_req = 1'b0;
    idle(6);
    check("t5_ram_kept", 32'(ram[8'h40]), 32'hC1);
    check("t5_ovf_sticky", 32'(spi_ovf), 1);
    spi_send(2'b00, 8'h70);
    spi_send(2'b01, 8'h77);
    check("t5_wr_en",    32'(mem_en), 1);
    check("t5_wr_addr",  32'(mem_addr), 32'h70);
    check("t5_wr_wdata", 32'(mem_wdata), 32'h77);
    tick();
    check("t5_ram_new", 32'(ram[8'h70]), 32'h77);
    check("t5_ovf_end", 32'(spi_ovf), 1);

    // 6: reset during the ACCESS cycle of a host read
    idle(3);
    preload(8'h09, 8'h55);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h09;
    tick();
    check("t6_gnt", 32'(host_gnt), 1);
    rst_n    = 1'b0;
    host_req = 1'b0;
    tick();
    check("t6_mem_en",   32'(mem_en), 0);
    check("t6_mem_addr", 32'(mem_addr), 0);
    check("t6_gnt_clr",  32'(host_gnt), 0);
    check("t6_ovf_clr",  32'(spi_ovf), 0);
    check("t6_rdata",    32'(host_rdata), 0);
    rst_n = 1'b1;
    tick();
    check("t6_no_rv1", 32'(host_rvalid), 0);
    tick();
    check("t6_no_rv2", 32'(host_rvalid), 0);
    spi_send(2'b01, 8'hDD);
    check("t6_wr_en",    32'(mem_en), 1);
    check("t6_wr_addr",  32'(mem_addr), 0);
    check("t6_wr_wdata", 32'(mem_wdata), 32'hDD);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
